// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, fixed-latency memory between instruction fetch and data access.
// Issue/wait/response FSM with data priority and a bounded fetch starvation window.

module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_kill,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ready,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] LAT_INIT   = 4'(MEM_LAT);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t              state_r;
  state_t              nextState_s;

  logic                grantIf_s;
  logic                grantDm_s;
  logic                ifEligible_s;
  logic                lastCycle_s;
  logic                killSeen_s;

  logic                ownerIf_r;
  logic [ADDR_W-1:0]   addr_r;
  logic                we_r;
  logic [DATA_W-1:0]   wdata_r;
  logic [3:0]          waitCnt_r;
  logic [3:0]          starveCnt_r;
  logic                killFlag_r;

  logic                memEn_s;
  logic                busy_s;
  logic                ifReady_s;
  logic                dmReady_s;
  logic                captureIf_s;
  logic                captureDm_s;

  logic                memEn_r;
  logic                busy_r;
  logic                ifReady_r;
  logic                dmReady_r;
  logic [DATA_W-1:0]   ifRdata_r;
  logic [DATA_W-1:0]   dmRdata_r;

  // Arbitration: data wins unless fetch has been starved for STARVE_MAX grants.
  always_comb begin
    ifEligible_s = if_req & ~if_kill;
    grantIf_s    = 1'b0;
    grantDm_s    = 1'b0;
    if (state_r == IDLE) begin
      grantIf_s = ifEligible_s & ((starveCnt_r == STARVE_LIM) | ~dm_req);
      grantDm_s = dm_req & ~grantIf_s;
    end else begin
      grantIf_s = 1'b0;
      grantDm_s = 1'b0;
    end
  end

  assign lastCycle_s = (state_r == BUSY) && (waitCnt_r <= 4'd1);
  assign killSeen_s  = killFlag_r | if_kill;

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= nextState_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    nextState_s = state_r;
    case (state_r)
      IDLE: begin
        if (grantIf_s || grantDm_s) begin
          nextState_s = BUSY;
        end else begin
          nextState_s = IDLE;
        end
      end
      BUSY: begin
        if (lastCycle_s) begin
          nextState_s = RESP;
        end else begin
          nextState_s = BUSY;
        end
      end
      RESP:    nextState_s = IDLE;
      default: nextState_s = IDLE;
    endcase
  end

  // FSM output decode, computed one cycle early so every output leaves a flop.
  always_comb begin
    memEn_s     = (nextState_s == BUSY);
    busy_s      = (nextState_s != IDLE);
    ifReady_s   = 1'b0;
    dmReady_s   = 1'b0;
    captureIf_s = 1'b0;
    captureDm_s = 1'b0;
    if (lastCycle_s) begin
      ifReady_s   = ownerIf_r & ~killSeen_s;
      dmReady_s   = ~ownerIf_r;
      captureIf_s = ownerIf_r & ~killSeen_s;
      captureDm_s = ~ownerIf_r & ~we_r;
    end else begin
      ifReady_s   = 1'b0;
      dmReady_s   = 1'b0;
      captureIf_s = 1'b0;
      captureDm_s = 1'b0;
    end
  end

  // Access latch: owner, address, write data and the latency down-counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ownerIf_r <= 1'b0;
      addr_r    <= '0;
      we_r      <= 1'b0;
      wdata_r   <= '0;
      waitCnt_r <= 4'd0;
    end else if (grantIf_s || grantDm_s) begin
      ownerIf_r <= grantIf_s;
      addr_r    <= grantIf_s ? if_addr : dm_addr;
      we_r      <= grantDm_s & dm_we;
      wdata_r   <= grantIf_s ? '0 : dm_wdata;
      waitCnt_r <= LAT_INIT;
    end else if (state_r == BUSY) begin
      waitCnt_r <= waitCnt_r - 4'd1;
      if (lastCycle_s) begin
        we_r <= 1'b0;
      end
    end
  end

  // Starvation counter: counts data grants that overtook a pending fetch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starveCnt_r <= 4'd0;
    end else if (grantDm_s && if_req) begin
      if (starveCnt_r < STARVE_LIM) begin
        starveCnt_r <= starveCnt_r + 4'd1;
      end
    end else if (grantDm_s || grantIf_s) begin
      starveCnt_r <= 4'd0;
    end
  end

  // Kill flag: a redirect while fetch owns the port suppresses its response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      killFlag_r <= 1'b0;
    end else if (nextState_s == IDLE) begin
      killFlag_r <= 1'b0;
    end else if ((state_r != IDLE) && ownerIf_r && if_kill) begin
      killFlag_r <= 1'b1;
    end
  end

  // Output registers, including the per-requester read data holding registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      memEn_r   <= 1'b0;
      busy_r    <= 1'b0;
      ifReady_r <= 1'b0;
      dmReady_r <= 1'b0;
      ifRdata_r <= '0;
      dmRdata_r <= '0;
    end else begin
      memEn_r   <= memEn_s;
      busy_r    <= busy_s;
      ifReady_r <= ifReady_s;
      dmReady_r <= dmReady_s;
      if (captureIf_s) begin
        ifRdata_r <= mem_rdata;
      end
      if (captureDm_s) begin
        dmRdata_r <= mem_rdata;
      end
    end
  end

  assign mem_en    = memEn_r;
  assign mem_we    = we_r;
  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;
  assign busy      = busy_r;
  assign if_ready  = ifReady_r;
  assign dm_ready  = dmReady_r;
  assign if_rdata  = ifRdata_r;
  assign dm_rdata  = dmRdata_r;

  mem_port_arbiter_chk u_chk (
    .clk      (clk),
    .reset    (reset),
    .if_ready (if_ready),
    .dm_ready (dm_ready),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .busy     (busy)
  );

endmodule

// Protocol invariants of the arbiter outputs.
module mem_port_arbiter_chk (
  input logic clk,
  input logic reset,
  input logic if_ready,
  input logic dm_ready,
  input logic mem_en,
  input logic mem_we,
  input logic busy
);

  readyExclusive: assert property (@(posedge clk) disable iff (!reset) !(if_ready && dm_ready));
  enImpliesBusy:  assert property (@(posedge clk) disable iff (!reset) (!mem_en || busy));
  weImpliesEn:    assert property (@(posedge clk) disable iff (!reset) (!mem_we || mem_en));

endmodule
